// File: rtl/chacha20_xor_stream.sv
// ChaCha20 stream XOR engine: requests keystream blocks from the generator and
// XORs them word by word onto a 32-bit AXI-Stream payload (encrypt == decrypt).
module chacha20_xor_stream #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                     i_aclk,
    input  logic                     i_aresetn,
    input  logic                     i_enable,
    input  logic [31:0]              i_counter_init,
    output logic                     o_ks_start,
    output logic [31:0]              o_ks_counter,
    input  logic [16*DATA_WIDTH-1:0] i_keystream,
    input  logic                     i_keystream_valid,
    input  logic [DATA_WIDTH-1:0]    i_s_tdata,
    input  logic                     i_s_tvalid,
    input  logic                     i_s_tlast,
    output logic                     o_s_tready,
    output logic [DATA_WIDTH-1:0]    o_m_tdata,
    output logic                     o_m_tvalid,
    output logic                     o_m_tlast,
    input  logic                     i_m_tready,
    output logic                     o_busy,
    output logic                     o_ks_unexpected
);

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT_KS, STREAM} state_e;

    state_e                  state_q, state_d;
    logic [31:0]             ctr_q, ctr_d;
    logic [16*DATA_WIDTH-1:0] buf_q, buf_d;
    logic [3:0]              idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   mdata_q, mdata_d;
    logic                    mlast_q, mlast_d;
    logic                    mvalid_q, mvalid_d;
    logic                    unexp_q, unexp_d;
    logic [DATA_WIDTH-1:0]   ks_word;
    logic                    hs;

    assign ks_word = buf_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
    assign hs      = o_s_tready && i_s_tvalid;

    // State register
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_enable && i_s_tvalid) state_d = REQUEST;
            REQUEST: state_d = WAIT_KS;
            WAIT_KS: if (i_keystream_valid) state_d = STREAM;
            STREAM: begin
                if (hs) begin
                    if (i_s_tlast)         state_d = IDLE;
                    else if (idx_q == 4'd15) state_d = REQUEST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control outputs
    always_comb begin
        o_ks_start = (state_q == REQUEST);
        o_busy     = (state_q != IDLE);
        o_s_tready = (state_q == STREAM) && (!mvalid_q || i_m_tready);
    end

    // Datapath: counter, keystream buffer, word index and output register
    always_comb begin
        ctr_d    = ctr_q;
        buf_d    = buf_q;
        idx_d    = idx_q;
        mdata_d  = mdata_q;
        mlast_d  = mlast_q;
        mvalid_d = mvalid_q;
        unexp_d  = unexp_q || (i_keystream_valid && state_q != WAIT_KS);
        if (state_q == IDLE && i_enable && i_s_tvalid) ctr_d = i_counter_init;
        if (state_q == WAIT_KS && i_keystream_valid) begin
            buf_d = i_keystream;
            idx_d = 4'd0;
        end
        if (hs) begin
            mdata_d  = i_s_tdata ^ ks_word;
            mlast_d  = i_s_tlast;
            mvalid_d = 1'b1;
            idx_d    = idx_q + 4'd1;
            // tlast on word 15 ends the packet without fetching another block
            if (!i_s_tlast && idx_q == 4'd15) ctr_d = ctr_q + 32'd1;
        end else if (i_m_tready) begin
            mvalid_d = 1'b0;
        end
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            ctr_q    <= '0;
            buf_q    <= '0;
            idx_q    <= '0;
            mdata_q  <= '0;
            mlast_q  <= 1'b0;
            mvalid_q <= 1'b0;
            unexp_q  <= 1'b0;
        end else begin
            ctr_q    <= ctr_d;
            buf_q    <= buf_d;
            idx_q    <= idx_d;
            mdata_q  <= mdata_d;
            mlast_q  <= mlast_d;
            mvalid_q <= mvalid_d;
            unexp_q  <= unexp_d;
        end
    end

    assign o_ks_counter    = ctr_q;
    assign o_m_tdata       = mdata_q;
    assign o_m_tlast       = mlast_q;
    assign o_m_tvalid      = mvalid_q;
    assign o_ks_unexpected = unexp_q;

endmodule

// File: tb/tb_chacha20_xor_stream.sv
// Directed bench for chacha20_xor_stream with a keystream generator stub
// (block returned 20 cycles after each request, word k = A5A5_<ctr[7:0]>_k).
module tb_chacha20_xor_stream;

    logic          i_aclk = 1'b0;
    logic          i_aresetn = 1'b0;
    logic          i_enable = 1'b1;
    logic [31:0]   i_counter_init = '0;
    logic          o_ks_start;
    logic [31:0]   o_ks_counter;
    logic [511:0]  i_keystream = '0;
    logic          i_keystream_valid = 1'b0;
    logic [31:0]   i_s_tdata = '0;
    logic          i_s_tvalid = 1'b0;
    logic          i_s_tlast = 1'b0;
    logic          o_s_tready;
    logic [31:0]   o_m_tdata;
    logic          o_m_tvalid;
    logic          o_m_tlast;
    logic          i_m_tready = 1'b1;
    logic          o_busy;
    logic          o_ks_unexpected;

    int total = 0;
    int bad = 0;

    // stub / monitor state
    int          start_cnt = 0;
    logic [31:0] start_ctr[$];
    logic [31:0] out_data[$];
    logic        out_last[$];
    int          ks_timer = 0;
    logic [31:0] ks_ctr = '0;
    bit          spur_req = 0;
    int          rdy_mode = 0;
    int          rdy_phase = 0;
    int          hold_viol = 0;
    int          trdy_viol = 0;
    int          stall_cnt = 0;

    chacha20_xor_stream #(.DATA_WIDTH(32)) dut (
        .i_aclk(i_aclk), .i_aresetn(i_aresetn), .i_enable(i_enable),
        .i_counter_init(i_counter_init), .o_ks_start(o_ks_start),
        .o_ks_counter(o_ks_counter), .i_keystream(i_keystream),
        .i_keystream_valid(i_keystream_valid), .i_s_tdata(i_s_tdata),
        .i_s_tvalid(i_s_tvalid), .i_s_tlast(i_s_tlast), .o_s_tready(o_s_tready),
        .o_m_tdata(o_m_tdata), .o_m_tvalid(o_m_tvalid), .o_m_tlast(o_m_tlast),
        .i_m_tready(i_m_tready), .o_busy(o_busy), .o_ks_unexpected(o_ks_unexpected)
    );

    always #5 i_aclk = ~i_aclk;

    function automatic logic [31:0] ksw(input logic [31:0] ctr, input int k);
        ksw = 32'hA5A50000 | {16'h0, ctr[7:0], 8'h00} | k;
    endfunction

    // Keystream generator stub
    initial forever begin
        @(posedge i_aclk); #1;
        i_keystream_valid = 1'b0;
        if (spur_req) begin
            i_keystream_valid = 1'b1;
            spur_req = 0;
        end else if (o_ks_start) begin
            start_cnt++;
            start_ctr.push_back(o_ks_counter);
            ks_ctr = o_ks_counter;
            ks_timer = 20;
        end else if (ks_timer > 0) begin
            ks_timer--;
            if (ks_timer == 0) begin
                for (int k = 0; k < 16; k++) i_keystream[32*k +: 32] = ksw(ks_ctr, k);
                i_keystream_valid = 1'b1;
            end
        end
    end

    // Master ready driver
    initial forever begin
        @(posedge i_aclk); #1;
        case (rdy_mode)
            1: begin
                i_m_tready = (rdy_phase == 0 || rdy_phase == 3);
                rdy_phase = (rdy_phase + 1) % 4;
            end
            2: i_m_tready = 1'b0;
            default: i_m_tready = 1'b1;
        endcase
    end

    // Output monitor
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        prev_stall = 0; prev_data = '0; prev_last = 0;
        forever begin
            @(negedge i_aclk);
            if (i_aresetn) begin
                if (prev_stall && (o_m_tdata !== prev_data || o_m_tlast !== prev_last || !o_m_tvalid))
                    hold_viol++;
                if (o_m_tvalid && !i_m_tready) begin
                    stall_cnt++;
                    if (o_s_tready) trdy_viol++;
                end
                if (o_m_tvalid && i_m_tready) begin
                    out_data.push_back(o_m_tdata);
                    out_last.push_back(o_m_tlast);
                end
                prev_stall = o_m_tvalid && !i_m_tready;
                prev_data = o_m_tdata;
                prev_last = o_m_tlast;
            end else begin
                prev_stall = 0;
            end
        end
    end

    task automatic clear_logs();
        start_cnt = 0;
        start_ctr.delete();
        out_data.delete();
        out_last.delete();
        hold_viol = 0; trdy_viol = 0; stall_cnt = 0;
    endtask

    task automatic send_packet(input int n, input logic [31:0] base, input logic [31:0] step);
        int guard;
        for (int k = 0; k < n; k++) begin
            @(posedge i_aclk); #1;
            i_s_tvalid = 1'b1;
            i_s_tdata = base + step * k;
            i_s_tlast = (k == n - 1);
            guard = 0;
            do begin
                @(negedge i_aclk);
                guard++;
            end while (!o_s_tready && guard < 400);
            if (!o_s_tready) begin
                total++; bad++;
                $display("FAIL send_timeout word=%0d got tready=0 exp tready=1", k);
                break;
            end
        end
        @(posedge i_aclk); #1;
        i_s_tvalid = 1'b0;
        i_s_tlast = 1'b0;
    endtask

    task automatic wait_out(input int n);
        for (int c = 0; c < 400 && out_data.size() < n; c++) @(negedge i_aclk);
        repeat (2) @(negedge i_aclk);
        total++;
        if (out_data.size() !== n) begin
            bad++;
            $display("FAIL out_count got %0d exp %0d", out_data.size(), n);
        end
    endtask

    task automatic check_words(input string nm, input int n, input logic [31:0] base,
                               input logic [31:0] step, input logic [31:0] ctr0);
        logic [31:0] exp;
        logic [31:0] c;
        for (int k = 0; k < n && k < out_data.size(); k++) begin
            c = ctr0 + k / 16;
            exp = (base + step * k) ^ ksw(c, k % 16);
            total++;
            if (out_data[k] !== exp || out_last[k] !== (k == n - 1)) begin
                bad++;
                $display("FAIL %s word=%0d got %h/%b exp %h/%b", nm, k, out_data[k],
                         out_last[k], exp, (k == n - 1));
            end
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({o_ks_start, o_ks_counter, o_s_tready, o_m_tvalid, o_m_tdata, o_m_tlast,
             o_busy, o_ks_unexpected} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got nonzero cnt=%h data=%h exp all 0", o_ks_counter, o_m_tdata);
        end
        repeat (2) @(posedge i_aclk);
        #1 i_aresetn = 1'b1;
    endtask

    task automatic test_single_word();
        clear_logs();
        i_counter_init = 32'd1;
        send_packet(1, 32'h0, 32'h0);
        wait_out(1);
        total++;
        if (out_data.size() > 0 && (out_data[0] !== 32'hA5A50100 || out_last[0] !== 1'b1)) begin
            bad++;
            $display("FAIL single_word got %h/%b exp a5a50100/1", out_data[0], out_last[0]);
        end
        total++;
        if (start_cnt !== 1 || start_ctr[0] !== 32'd1) begin
            bad++;
            $display("FAIL single_starts got %0d exp 1", start_cnt);
        end
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle got busy=%b exp 0", o_busy);
        end
    endtask

    task automatic test_two_blocks();
        clear_logs();
        i_counter_init = 32'd1;
        send_packet(20, 32'hFFFFFFFF, 32'h0);
        wait_out(20);
        check_words("two_blocks", 20, 32'hFFFFFFFF, 32'h0, 32'd1);
        total++;
        if (out_data.size() > 16 && out_data[16] !== ~32'hA5A50200) begin
            bad++;
            $display("FAIL two_blocks_w16 got %h exp %h", out_data[16], ~32'hA5A50200);
        end
        total++;
        if (start_cnt !== 2 || start_ctr[0] !== 32'd1 || start_ctr[1] !== 32'd2) begin
            bad++;
            $display("FAIL two_blocks_starts got %0d exp 2 (ctr 1,2)", start_cnt);
        end
    endtask

    task automatic test_counter_wrap();
        clear_logs();
        i_counter_init = 32'hFFFFFFFF;
        send_packet(17, 32'h12345678, 32'h0);
        wait_out(17);
        check_words("wrap", 17, 32'h12345678, 32'h0, 32'hFFFFFFFF);
        total++;
        if (start_cnt !== 2 || start_ctr[1] !== 32'h0) begin
            bad++;
            $display("FAIL wrap_ctr got cnt=%0d exp 2 with second ctr 00000000", start_cnt);
        end
        total++;
        if (out_data.size() > 16 && out_data[16] !== (32'hA5A50000 ^ 32'h12345678)) begin
            bad++;
            $display("FAIL wrap_w16 got %h exp %h", out_data[16], 32'hA5A50000 ^ 32'h12345678);
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        i_counter_init = 32'd5;
        rdy_phase = 0;
        rdy_mode = 1;
        send_packet(8, 32'h0, 32'h01010101);
        wait_out(8);
        rdy_mode = 0;
        check_words("backpressure", 8, 32'h0, 32'h01010101, 32'd5);
        total++;
        if (stall_cnt == 0 || hold_viol !== 0) begin
            bad++;
            $display("FAIL bp_hold got viol=%0d stalls=%0d exp viol=0 stalls>0", hold_viol, stall_cnt);
        end
        total++;
        if (trdy_viol !== 0) begin
            bad++;
            $display("FAIL bp_tready got %0d exp 0", trdy_viol);
        end
    endtask

    task automatic test_tlast_w15();
        clear_logs();
        i_counter_init = 32'd3;
        send_packet(16, 32'h11110000, 32'h1);
        wait_out(16);
        check_words("tlast15", 16, 32'h11110000, 32'h1, 32'd3);
        repeat (30) @(negedge i_aclk);
        total++;
        if (start_cnt !== 1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL tlast15_starts got %0d busy=%b exp 1 busy=0", start_cnt, o_busy);
        end
        clear_logs();
        send_packet(1, 32'hCAFEF00D, 32'h0);
        wait_out(1);
        total++;
        if (start_ctr.size() != 1 || start_ctr[0] !== 32'd3 ||
            out_data[0] !== (32'hCAFEF00D ^ 32'hA5A50300)) begin
            bad++;
            $display("FAIL tlast15_restart got %h exp %h", out_data[0], 32'hCAFEF00D ^ 32'hA5A50300);
        end
    endtask

    task automatic test_spurious_and_reset();
        int guard;
        total++;
        if (o_ks_unexpected !== 1'b0) begin
            bad++;
            $display("FAIL unexp_initial got %b exp 0", o_ks_unexpected);
        end
        spur_req = 1;
        repeat (3) @(negedge i_aclk);
        total++;
        if (o_ks_unexpected !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL unexp_set got %b busy=%b exp 1 busy=0", o_ks_unexpected, o_busy);
        end
        repeat (5) @(negedge i_aclk);
        total++;
        if (o_ks_unexpected !== 1'b1) begin
            bad++;
            $display("FAIL unexp_sticky got %b exp 1", o_ks_unexpected);
        end
        // start a packet and park an output word behind a stalled sink
        clear_logs();
        i_counter_init = 32'd7;
        rdy_mode = 2;
        @(posedge i_aclk); #1;
        i_s_tvalid = 1'b1;
        i_s_tdata = 32'h0F0F0F0F;
        guard = 0;
        do begin
            @(negedge i_aclk);
            guard++;
        end while (!o_m_tvalid && guard < 400);
        total++;
        if (o_m_tvalid !== 1'b1 || o_busy !== 1'b1 || o_m_tdata !== (32'h0F0F0F0F ^ 32'hA5A50700)) begin
            bad++;
            $display("FAIL midblock got v=%b d=%h exp v=1 d=%h", o_m_tvalid, o_m_tdata,
                     32'h0F0F0F0F ^ 32'hA5A50700);
        end
        i_aresetn = 1'b0;
        i_s_tvalid = 1'b0;
        #1;
        total++;
        if ({o_ks_start, o_ks_counter, o_s_tready, o_m_tvalid, o_m_tdata, o_m_tlast,
             o_busy, o_ks_unexpected} !== '0) begin
            bad++;
            $display("FAIL midreset got cnt=%h d=%h v=%b busy=%b exp all 0", o_ks_counter,
                     o_m_tdata, o_m_tvalid, o_busy);
        end
        repeat (2) @(posedge i_aclk);
        #1 i_aresetn = 1'b1;
        rdy_mode = 0;
        repeat (3) @(negedge i_aclk);
        total++;
        if (o_busy !== 1'b0 || o_m_tvalid !== 1'b0 || o_ks_unexpected !== 1'b0) begin
            bad++;
            $display("FAIL post_reset got busy=%b v=%b unexp=%b exp 0", o_busy, o_m_tvalid, o_ks_unexpected);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_blocks();
        test_counter_wrap();
        test_backpressure();
        test_tlast_w15();
        test_spurious_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

endmodule
